// File: rtl/sram_pkg.sv
// Shared types and constants for the 1RW1R byte-masked SRAM.
// The controller state enum lives here so the bench and RTL agree on encoding.
package sram_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int BYTE_WIDTH         = 8;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/sram_1rw1r_wmask_if.sv
// Request/response bundle for the 1RW1R SRAM.
// The master drives both request ports; the slave (the memory) returns read data and status.
interface sram_1rw1r_wmask_if
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

  logic                  csb0;
  logic                  web0;
  logic [NUM_BYTES-1:0]  wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  busy;
  logic                  collision1;

  modport master (
    output csb0, web0, wmask0, addr0, din0, csb1, addr1,
    input  dout0, dout1, busy, collision1
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
    output dout0, dout1, busy, collision1
  );

endinterface

// File: rtl/sram_init_ctrl.sv
// Post-reset controller: optionally sweeps zeros through the array, one word per cycle,
// and holds the memory busy until the sweep finishes.
module sram_init_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  ctrl_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments only; blocking here would
  // let downstream flops in the same edge see the new value and break the register model.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RESET: begin
        state_d = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
        cnt_d   = '0;
      end
      // Stop on all-ones rather than wrap so the counter never revisits address 0.
      ST_CLEAR: begin
        if (cnt_q == '1) state_d = ST_READY;
        else             cnt_d   = cnt_q + ADDR_WIDTH'(1);
      end
      ST_READY: ;
      default:  state_d = ST_RESET;
    endcase
  end

  assign busy     = (state_q != ST_READY);
  assign clr_we   = (state_q == ST_CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/sram_1rw1r_wmask.sv
// Behavioural 1RW1R SRAM with per-byte write mask, read-first collision behaviour
// and an optional zeroing sweep after reset. The bus interface widths must match the parameters.
module sram_1rw1r_wmask
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk0,
  input  logic                     rst0,
  sram_1rw1r_wmask_if.slave        bus
);

  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  logic                  busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  sram_init_ctrl #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_init_ctrl (
    .clk0     (clk0),
    .rst0     (rst0),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // rst0 is folded in because the controller only reports busy one edge after reset.
  logic p0_wr, p0_rd, p1_rd;
  assign p0_wr = !rst0 && !busy && !bus.csb0 && !bus.web0;
  assign p0_rd = !rst0 && !busy && !bus.csb0 &&  bus.web0;
  assign p1_rd = !rst0 && !busy && !bus.csb1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch; a reset on storage would block macro inference,
  // and zeroing is the job of the controller's sweep.
  always_ff @(posedge clk0) begin
    if (clr_we && !rst0) begin
      mem[clr_addr] <= '0;
    end else if (p0_wr) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (bus.wmask0[b]) mem[bus.addr0][b*BYTE_WIDTH +: BYTE_WIDTH] <= bus.din0[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  logic [DATA_WIDTH-1:0] dout0_q, dout1_q;
  logic                  collision1_q;

  // Reads sample mem before this edge's write lands, giving read-first on a same-address clash.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      dout0_q      <= '0;
      dout1_q      <= '0;
      collision1_q <= 1'b0;
    end else begin
      collision1_q <= p0_wr && p1_rd && (bus.addr0 == bus.addr1);
      if (p0_rd) dout0_q <= mem[bus.addr0];
      if (p1_rd) dout1_q <= mem[bus.addr1];
    end
  end

  assign bus.dout0      = dout0_q;
  assign bus.dout1      = dout1_q;
  assign bus.collision1 = collision1_q;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// Scoreboard bench for sram_1rw1r_wmask: one instance with the clear sweep, one without.
module tb_sram_1rw1r_wmask;
  import sram_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NB    = DW / BYTE_WIDTH;
  localparam int DEPTH = 1 << AW;

  typedef enum int {S_A_DOUT0, S_A_DOUT1, S_A_COLL, S_A_BUSY, S_B_DOUT0, S_B_DOUT1, S_B_BUSY} sig_e;

  typedef struct {
    string          tag;
    sig_e           sig;
    logic [DW-1:0]  exp;
  } sb_entry_t;

  logic clk0 = 1'b0;
  logic rst_a, rst_b;

  sram_1rw1r_wmask_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
  sram_1rw1r_wmask_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

  sram_1rw1r_wmask #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk0 (clk0),
    .rst0 (rst_a),
    .bus  (bus_a.slave)
  );

  sram_1rw1r_wmask #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk0 (clk0),
    .rst0 (rst_b),
    .bus  (bus_b.slave)
  );

  always #5 clk0 = ~clk0;

  sb_entry_t     sb[$];
  int            n_checks;
  int            n_pass;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_d0, exp_d1;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] sample(input sig_e s);
    logic [DW-1:0] v;
    v = 'x;
    case (s)
      S_A_DOUT0: v = bus_a.dout0;
      S_A_DOUT1: v = bus_a.dout1;
      S_A_COLL:  v = {{(DW-1){1'b0}}, bus_a.collision1};
      S_A_BUSY:  v = {{(DW-1){1'b0}}, bus_a.busy};
      S_B_DOUT0: v = bus_b.dout0;
      S_B_DOUT1: v = bus_b.dout1;
      S_B_BUSY:  v = {{(DW-1){1'b0}}, bus_b.busy};
      default:   v = 'x;
    endcase
    return v;
  endfunction

  task automatic expect_sig(input string tag, input sig_e s, input logic [DW-1:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.sig = s;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // Advance one edge, then retire every expectation queued for that edge.
  task automatic tick();
    sb_entry_t e;
    @(posedge clk0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, sample(e.sig), e.exp);
    end
  endtask

  task automatic idle_a();
    bus_a.csb0 = 1'b1; bus_a.web0 = 1'b1; bus_a.wmask0 = '0; bus_a.addr0 = '0;
    bus_a.din0 = '0;   bus_a.csb1 = 1'b1; bus_a.addr1 = '0;
  endtask

  task automatic idle_b();
    bus_b.csb0 = 1'b1; bus_b.web0 = 1'b1; bus_b.wmask0 = '0; bus_b.addr0 = '0;
    bus_b.din0 = '0;   bus_b.csb1 = 1'b1; bus_b.addr1 = '0;
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [NB-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < NB; b++)
      if (m[b]) r[b*BYTE_WIDTH +: BYTE_WIDTH] = d[b*BYTE_WIDTH +: BYTE_WIDTH];
    return r;
  endfunction

  // One ready-state cycle on instance A with model-derived expectations.
  task automatic step_a(input string tag, input bit p0_en, input bit p0_wr, input logic [NB-1:0] m,
                        input logic [AW-1:0] a0, input logic [DW-1:0] d,
                        input bit p1_en, input logic [AW-1:0] a1);
    bus_a.csb0 = !p0_en; bus_a.web0 = !p0_wr; bus_a.wmask0 = m; bus_a.addr0 = a0;
    bus_a.din0 = d;      bus_a.csb1 = !p1_en; bus_a.addr1 = a1;
    if (p1_en) exp_d1 = model[a1];
    if (p0_en && !p0_wr) exp_d0 = model[a0];
    expect_sig({tag, ".dout0"}, S_A_DOUT0, exp_d0);
    expect_sig({tag, ".dout1"}, S_A_DOUT1, exp_d1);
    expect_sig({tag, ".coll"},  S_A_COLL,  (p0_en && p0_wr && p1_en && a0 == a1) ? 32'd1 : 32'd0);
    expect_sig({tag, ".busy"},  S_A_BUSY,  32'd0);
    if (p0_en && p0_wr) model[a0] = merge(model[a0], d, m);
    tick();
    idle_a();
  endtask

  // Count busy cycles after reset release; optionally fire requests that must be ignored.
  task automatic count_busy_a(output int n, input bit poke);
    n = 0;
    while (bus_a.busy === 1'b1 && n < 100) begin
      n++;
      if (poke) begin
        if (n[0]) begin
          bus_a.csb0 = 1'b0; bus_a.web0 = 1'b0; bus_a.wmask0 = '1; bus_a.addr0 = AW'(2);
          bus_a.din0 = 32'hFFFF_FFFF; bus_a.csb1 = 1'b0; bus_a.addr1 = AW'(2);
        end else begin
          bus_a.csb0 = 1'b0; bus_a.web0 = 1'b1; bus_a.addr0 = AW'(7);
        end
        expect_sig("busy_req.dout0", S_A_DOUT0, exp_d0);
        expect_sig("busy_req.dout1", S_A_DOUT1, exp_d1);
        expect_sig("busy_req.coll",  S_A_COLL,  32'd0);
      end
      tick();
      idle_a();
    end
  endtask

  task automatic sweep_read_a(input string tag);
    for (int i = 0; i < DEPTH; i++)
      step_a($sformatf("%s[%0d]", tag, i), 1'b1, 1'b0, '0, AW'(DEPTH-1-i), '0, 1'b1, AW'(i));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    n_checks = 0;
    n_pass   = 0;
    exp_d0   = '0;
    exp_d1   = '0;
    idle_a();
    idle_b();
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) tick();

    check("a_rst.busy",  {31'b0, bus_a.busy}, 32'd1);
    check("a_rst.dout0", bus_a.dout0, 32'd0);
    check("a_rst.dout1", bus_a.dout1, 32'd0);
    check("a_rst.coll",  {31'b0, bus_a.collision1}, 32'd0);

    // Instance B: no sweep; seed a word, reset again, confirm it survives.
    rst_b = 1'b0;
    repeat (2) tick();
    bus_b.csb0 = 1'b0; bus_b.web0 = 1'b0; bus_b.wmask0 = '1; bus_b.addr0 = AW'(4);
    bus_b.din0 = 32'h1234_5678;
    tick();
    idle_b();
    rst_b = 1'b1;
    tick();
    check("b_rst.busy", {31'b0, bus_b.busy}, 32'd1);
    rst_b = 1'b0;
    check("b_rel.busy", {31'b0, bus_b.busy}, 32'd1);
    bus_b.csb0 = 1'b0; bus_b.web0 = 1'b0; bus_b.wmask0 = '1; bus_b.addr0 = AW'(4);
    bus_b.din0 = 32'hDEAD_BEEF;
    expect_sig("b_ready.busy", S_B_BUSY, 32'd0);
    tick();
    idle_b();
    bus_b.csb0 = 1'b0; bus_b.addr0 = AW'(4); bus_b.csb1 = 1'b0; bus_b.addr1 = AW'(4);
    expect_sig("b_first_rd.dout0", S_B_DOUT0, 32'h1234_5678);
    expect_sig("b_first_rd.dout1", S_B_DOUT1, 32'h1234_5678);
    expect_sig("b_first_rd.busy",  S_B_BUSY,  32'd0);
    tick();
    idle_b();

    // Instance A: full sweep after reset.
    rst_a = 1'b0;
    count_busy_a(n, 1'b0);
    check("a_clear.busy_cycles", n, 32'd17);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    sweep_read_a("a_clear_rd");

    step_a("w3_full", 1'b1, 1'b1, 4'b1111, AW'(3), 32'hAABB_CCDD, 1'b0, '0);
    step_a("w3_mask", 1'b1, 1'b1, 4'b0101, AW'(3), 32'h1122_3344, 1'b0, '0);
    step_a("r3",      1'b1, 1'b0, '0,      AW'(3), '0,            1'b0, '0);
    check("r3.value", bus_a.dout0, 32'hAA22_CC44);

    step_a("w5_init", 1'b1, 1'b1, 4'b1111, AW'(5), 32'h0000_0007, 1'b0, '0);
    step_a("coll5",   1'b1, 1'b1, 4'b1111, AW'(5), 32'hDEAD_BEEF, 1'b1, AW'(5));
    check("coll5.old",  bus_a.dout1, 32'h0000_0007);
    check("coll5.flag", {31'b0, bus_a.collision1}, 32'd1);
    step_a("r5_after", 1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(5));
    check("r5_after.new",  bus_a.dout1, 32'hDEAD_BEEF);
    check("r5_after.flag", {31'b0, bus_a.collision1}, 32'd0);

    step_a("w6_nomask", 1'b1, 1'b1, 4'b0000, AW'(6), 32'hFFFF_FFFF, 1'b1, AW'(6));
    step_a("r6",        1'b1, 1'b0, '0,      AW'(6), '0,            1'b0, '0);
    check("r6.value", bus_a.dout0, 32'h0000_0000);
    step_a("w9_hi",   1'b1, 1'b1, 4'b1000, AW'(9), 32'h5566_7788, 1'b0, '0);
    step_a("hold",    1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    step_a("r5_r9",   1'b1, 1'b0, '0, AW'(5), '0, 1'b1, AW'(9));
    check("r9.value", bus_a.dout1, 32'h5500_0000);

    // Reset with live data on the outputs, then abort a sweep at counter 9.
    rst_a = 1'b1;
    tick();
    check("a_rst2.dout0", bus_a.dout0, 32'd0);
    check("a_rst2.dout1", bus_a.dout1, 32'd0);
    check("a_rst2.busy",  {31'b0, bus_a.busy}, 32'd1);
    rst_a = 1'b0;
    repeat (10) tick();
    rst_a = 1'b1;
    tick();
    check("a_abort.dout0", bus_a.dout0, 32'd0);
    check("a_abort.dout1", bus_a.dout1, 32'd0);
    check("a_abort.busy",  {31'b0, bus_a.busy}, 32'd1);
    exp_d0 = '0;
    exp_d1 = '0;
    rst_a = 1'b0;
    count_busy_a(n, 1'b1);
    check("a_reclear.busy_cycles", n, 32'd17);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    sweep_read_a("a_reclear_rd");
    step_a("r2", 1'b1, 1'b0, '0, AW'(2), '0, 1'b0, '0);
    check("r2.value", bus_a.dout0, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
